// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like memory port between the instruction-fetch
// master and the mem-stage data master.
// An in-order ordering FIFO records which master owns each accepted transaction
// so that every returning data_ok/rdata is routed back to the master that issued it.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration. When it is
// undefined, the arbiter uses fixed priority with the data master first.

module mem_bus_arbiter #(
   parameter int unsigned OUTSTANDING = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,

   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,

   output logic              busy
);

   // A depth of 1 still needs a 1-bit pointer. In that case the pointer always stays at 0.
   localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned CntW = $clog2(OUTSTANDING) + 1;

   typedef enum logic [1:0] {
      GntNone = 2'd0,
      GntInst = 2'd1,
      GntData = 2'd2
   } gnt_e;

   // The lock state remembers a winner whose request is still waiting for m_addr_ok.
   typedef enum logic [1:0] {
      StFree     = 2'd0,
      StLockInst = 2'd1,
      StLockData = 2'd2
   } lock_e;

   lock_e state_q, state_d;
   gnt_e  arb_win;
   gnt_e  gnt;

   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        count_q;
   logic [OUTSTANDING-1:0] fifo_q;      // 1 = DATA owns the entry, 0 = INST

   logic full;
   logic push;
   logic pop;
   logic head_is_data;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(OUTSTANDING - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   assign full = (count_q == CntW'(OUTSTANDING));

`ifdef MEM_ARB_RR_EN
   logic last_q;                        // 1 = DATA was accepted most recently

   // Record which master had its address accepted most recently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b0;
      end else if (push) begin
         last_q <= (gnt == GntData);
      end
   end

   // Round-robin: on a tie, the master that was not accepted last wins.
   always_comb begin
      arb_win = GntNone;
      if (!rst) begin
         arb_win = GntNone;
      end else if (data_req && inst_req) begin
         arb_win = last_q ? GntInst : GntData;
      end else if (data_req) begin
         arb_win = GntData;
      end else if (inst_req) begin
         arb_win = GntInst;
      end
   end
`else
   // Fixed priority: the data master wins whenever it requests.
   always_comb begin
      arb_win = GntNone;
      if (!rst) begin
         arb_win = GntNone;
      end else if (data_req) begin
         arb_win = GntData;
      end else if (inst_req) begin
         arb_win = GntInst;
      end
   end
`endif

   // Lock state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFree;
      end else begin
         state_q <= state_d;
      end
   end

   // Next lock state: hold the winner while its request is pending without m_addr_ok.
   always_comb begin
      state_d = StFree;
      if (m_req && !m_addr_ok) begin
         case (gnt)
            GntInst: state_d = StLockInst;
            GntData: state_d = StLockData;
            default: state_d = StFree;
         endcase
      end
   end

   // Grant selection and request/address-handshake outputs.
   always_comb begin
      gnt = arb_win;
      // A locked master keeps the bus only while it still requests.
      case (state_q)
         StLockInst: if (inst_req) gnt = GntInst;
         StLockData: if (data_req) gnt = GntData;
         default:    gnt = arb_win;
      endcase

      m_req        = 1'b0;
      m_wr         = 1'b0;
      m_size       = 2'b00;
      m_addr       = '0;
      m_wdata      = '0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      case (gnt)
         GntInst: begin
            m_req        = !full;
            m_wr         = inst_wr;
            m_size       = inst_size;
            m_addr       = inst_addr;
            m_wdata      = inst_wdata;
            inst_addr_ok = !full && m_addr_ok;
         end
         GntData: begin
            m_req        = !full;
            m_wr         = data_wr;
            m_size       = data_size;
            m_addr       = data_addr;
            m_wdata      = data_wdata;
            data_addr_ok = !full && m_addr_ok;
         end
         default: begin
            m_req = 1'b0;
         end
      endcase
   end

   assign push = m_req && m_addr_ok;
   // A data_ok arriving with nothing outstanding is ignored.
   assign pop  = rst && m_data_ok && (count_q != '0);

   assign head_is_data = fifo_q[rd_ptr_q];

   // Route each response to the master that owns the FIFO head. Both masters see the read data.
   always_comb begin
      inst_data_ok = pop && !head_is_data;
      data_data_ok = pop && head_is_data;
      inst_rdata   = m_rdata;
      data_rdata   = m_rdata;
      busy         = (count_q != '0) || m_req;
   end

   // Ordering FIFO: push on accepted address, pop on returned data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fifo_q   <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= (gnt == GntData);
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (default build, fixed priority).
// A queue-based model of outstanding owners predicts every output each cycle.

module tb_mem_bus_arbiter;

   localparam int OUT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_addr_ok, m_data_ok;
   logic        busy;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .OUTSTANDING(OUT),
      .ADDR_W     (32),
      .DATA_W     (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_wr     (inst_wr),
      .inst_size   (inst_size),
      .inst_addr   (inst_addr),
      .inst_wdata  (inst_wdata),
      .inst_rdata  (inst_rdata),
      .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_size   (data_size),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_rdata  (data_rdata),
      .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .m_req       (m_req),
      .m_wr        (m_wr),
      .m_size      (m_size),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_addr_ok   (m_addr_ok),
      .m_data_ok   (m_data_ok),
      .busy        (busy)
   );

   int errors = 0;
   int checks = 0;

   // Model state: owners of accepted transactions in order (1 = INST, 2 = DATA),
   // plus the master that is waiting on m_addr_ok (0 = none).
   int q[$];
   int lock_own = 0;
   int own      = 0;
   int next_lock = 0;
   bit m_push   = 1'b0;
   bit m_pop    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Predict the outputs for the current inputs and compare, 1 time unit after the negedge.
   task automatic eval();
      logic        e_mreq, e_iaok, e_daok, e_idok, e_ddok, e_busy, e_wr;
      logic [1:0]  e_size;
      logic [31:0] e_addr, e_wdata;
      bit          full;
      #1;
      if (!rst) begin
         q.delete();
         lock_own  = 0;
         own       = 0;
         next_lock = 0;
         m_push    = 1'b0;
         m_pop     = 1'b0;
         chk("rst_m_req", m_req, 0);
         chk("rst_inst_addr_ok", inst_addr_ok, 0);
         chk("rst_data_addr_ok", data_addr_ok, 0);
         chk("rst_inst_data_ok", inst_data_ok, 0);
         chk("rst_data_data_ok", data_data_ok, 0);
         chk("rst_busy", busy, 0);
         chk("rst_inst_rdata", inst_rdata, m_rdata);
         chk("rst_data_rdata", data_rdata, m_rdata);
      end else begin
         if (lock_own == 1 && inst_req) own = 1;
         else if (lock_own == 2 && data_req) own = 2;
         else if (data_req) own = 2;
         else if (inst_req) own = 1;
         else own = 0;
         full    = (q.size() >= OUT);
         e_mreq  = (own != 0) && !full;
         e_wr    = (own == 2) ? data_wr : inst_wr;
         e_size  = (own == 2) ? data_size : inst_size;
         e_addr  = (own == 2) ? data_addr : inst_addr;
         e_wdata = (own == 2) ? data_wdata : inst_wdata;
         e_iaok  = e_mreq && (own == 1) && m_addr_ok;
         e_daok  = e_mreq && (own == 2) && m_addr_ok;
         m_pop   = m_data_ok && (q.size() > 0);
         e_idok  = m_pop && (q[0] == 1);
         e_ddok  = m_pop && (q[0] == 2);
         e_busy  = (q.size() > 0) || e_mreq;
         m_push  = e_mreq && m_addr_ok;
         next_lock = (e_mreq && !m_addr_ok) ? own : 0;
         chk("m_req", m_req, e_mreq);
         if (e_mreq) begin
            chk("m_wr", m_wr, e_wr);
            chk("m_size", m_size, e_size);
            chk("m_addr", m_addr, e_addr);
            chk("m_wdata", m_wdata, e_wdata);
         end
         chk("inst_addr_ok", inst_addr_ok, e_iaok);
         chk("data_addr_ok", data_addr_ok, e_daok);
         chk("inst_data_ok", inst_data_ok, e_idok);
         chk("data_data_ok", data_data_ok, e_ddok);
         chk("inst_rdata", inst_rdata, m_rdata);
         chk("data_rdata", data_rdata, m_rdata);
         chk("busy", busy, e_busy);
      end
   endtask

   // Clock edge: commit model state, then return to the next negedge for new inputs.
   task automatic adv();
      @(posedge clk);
      if (rst) begin
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(own);
         lock_own = next_lock;
      end
      @(negedge clk);
   endtask

   task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic aok,
                         input logic dok, input logic [31:0] rd);
      inst_req   = ir;
      inst_wr    = 1'b0;
      inst_size  = 2'd2;
      inst_addr  = ia;
      inst_wdata = 32'h0;
      data_req   = dr;
      data_wr    = dw;
      data_size  = 2'd2;
      data_addr  = da;
      data_wdata = dwd;
      m_addr_ok  = aok;
      m_data_ok  = dok;
      m_rdata    = rd;
   endtask

   task automatic idle(input logic dok, input logic [31:0] rd);
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, dok, rd);
   endtask

   initial begin
      // Reset with every input active: nothing may leak out.
      rst = 1'b0;
      set_in(1'b1, 32'h1FC00000, 1'b1, 1'b1, 32'h80000000, 32'h1, 1'b1, 1'b1, 32'h12345678);
      @(negedge clk);
      eval();
      adv();
      rst = 1'b1;

      // Single fetch read.
      set_in(1'b1, 32'h1FC00000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t1_inst_addr_ok", inst_addr_ok, 1);
      chk("t1_m_addr", m_addr, 32'h1FC00000);
      adv();
      idle(1'b0, 32'h0);
      eval();
      adv();
      idle(1'b1, 32'h3C080001);
      eval();
      chk("t1_inst_data_ok", inst_data_ok, 1);
      chk("t1_inst_rdata", inst_rdata, 32'h3C080001);
      chk("t1_data_data_ok", data_data_ok, 0);
      adv();

      // Conflict: data store wins, fetch accepted the next cycle, responses route DATA then INST.
      set_in(1'b1, 32'h1FC00004, 1'b1, 1'b1, 32'h80000010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t2_m_addr", m_addr, 32'h80000010);
      chk("t2_m_wr", m_wr, 1);
      chk("t2_m_size", m_size, 2);
      chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
      chk("t2_data_addr_ok", data_addr_ok, 1);
      chk("t2_inst_addr_ok", inst_addr_ok, 0);
      adv();
      set_in(1'b1, 32'h1FC00004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t2_inst_addr_ok_2", inst_addr_ok, 1);
      chk("t2_m_addr_2", m_addr, 32'h1FC00004);
      adv();
      idle(1'b1, 32'h11111111);
      eval();
      chk("t2_data_data_ok", data_data_ok, 1);
      chk("t2_inst_data_ok_0", inst_data_ok, 0);
      adv();
      idle(1'b1, 32'h22222222);
      eval();
      chk("t2_inst_data_ok", inst_data_ok, 1);
      chk("t2_data_data_ok_0", data_data_ok, 0);
      adv();

      // Lock on data: slave stalls 3 cycles while fetch keeps requesting.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 32'h1FC00010, 1'b1, 1'b0, 32'h80000020, 32'h0, 1'b0, 1'b0, 32'h0);
         eval();
         chk("t3_m_addr_stall", m_addr, 32'h80000020);
         chk("t3_inst_addr_ok_stall", inst_addr_ok, 0);
         adv();
      end
      set_in(1'b1, 32'h1FC00010, 1'b1, 1'b0, 32'h80000020, 32'h0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t3_data_addr_ok", data_addr_ok, 1);
      adv();
      set_in(1'b1, 32'h1FC00010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t3_inst_addr_ok", inst_addr_ok, 1);
      adv();
      idle(1'b1, 32'h0);
      eval();
      adv();
      idle(1'b1, 32'h0);
      eval();
      adv();

      // Lock on fetch: a late data request must not steal the stalled fetch.
      set_in(1'b1, 32'h1FC00008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      eval();
      adv();
      set_in(1'b1, 32'h1FC00008, 1'b1, 1'b1, 32'h80000030, 32'h5, 1'b0, 1'b0, 32'h0);
      eval();
      chk("t3b_m_addr_locked", m_addr, 32'h1FC00008);
      chk("t3b_m_wr_locked", m_wr, 0);
      adv();
      set_in(1'b1, 32'h1FC00008, 1'b1, 1'b1, 32'h80000030, 32'h5, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t3b_inst_addr_ok", inst_addr_ok, 1);
      chk("t3b_data_addr_ok", data_addr_ok, 0);
      adv();
      set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h80000030, 32'h5, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t3b_data_addr_ok_2", data_addr_ok, 1);
      adv();
      idle(1'b1, 32'h0);
      eval();
      chk("t3b_inst_data_ok", inst_data_ok, 1);
      adv();
      idle(1'b1, 32'h0);
      eval();
      chk("t3b_data_data_ok", data_data_ok, 1);
      adv();

      // Full: two accepted, the third waits; a pop does not release it in the same cycle.
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 32'h1FC00100 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
         eval();
         adv();
      end
      set_in(1'b1, 32'h1FC00108, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t4_full_m_req", m_req, 0);
      chk("t4_full_inst_addr_ok", inst_addr_ok, 0);
      chk("t4_full_busy", busy, 1);
      adv();
      set_in(1'b1, 32'h1FC00108, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
      eval();
      chk("t4_pop_m_req", m_req, 0);
      chk("t4_pop_inst_data_ok", inst_data_ok, 1);
      adv();
      set_in(1'b1, 32'h1FC00108, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t4_resume_m_req", m_req, 1);
      chk("t4_resume_inst_addr_ok", inst_addr_ok, 1);
      adv();
      idle(1'b1, 32'h0);
      eval();
      adv();
      idle(1'b1, 32'h0);
      eval();
      adv();

      // Spurious data_ok with nothing outstanding.
      idle(1'b1, 32'hCAFEF00D);
      eval();
      chk("t5_spur_inst_data_ok", inst_data_ok, 0);
      chk("t5_spur_data_data_ok", data_data_ok, 0);
      chk("t5_spur_busy", busy, 0);
      adv();
      idle(1'b0, 32'h0);
      eval();
      chk("t5_after_spur_busy", busy, 0);
      adv();

      // Reset with two outstanding empties the FIFO immediately.
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 32'h1FC00200 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
         eval();
         adv();
      end
      idle(1'b0, 32'h0);
      rst = 1'b0;
      eval();
      chk("t6_rst_busy", busy, 0);
      adv();
      rst = 1'b1;
      idle(1'b0, 32'h0);
      eval();
      chk("t6_post_rst_busy", busy, 0);
      adv();
      set_in(1'b1, 32'h1FC00300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t6_post_rst_accept", inst_addr_ok, 1);
      adv();
      idle(1'b1, 32'h0);
      eval();
      chk("t6_post_rst_inst_data_ok", inst_data_ok, 1);
      adv();

      // Randomised traffic, with an occasional reset pulse.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst        = ($urandom_range(0, 399) != 0);
         inst_req   = ($urandom_range(0, 2) != 0);
         inst_wr    = ($urandom_range(0, 7) == 0);
         inst_size  = 2'($urandom_range(0, 2));
         inst_addr  = $urandom;
         inst_wdata = $urandom;
         data_req   = ($urandom_range(0, 1) != 0);
         data_wr    = ($urandom_range(0, 1) != 0);
         data_size  = 2'($urandom_range(0, 2));
         data_addr  = $urandom;
         data_wdata = $urandom;
         m_addr_ok  = ($urandom_range(0, 1) != 0);
         m_rdata    = $urandom;
         if (q.size() > 0) m_data_ok = ($urandom_range(0, 1) != 0);
         else              m_data_ok = ($urandom_range(0, 15) == 0);
         eval();
         adv();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master to one-slave arbiter for the CPU's SRAM-like memory bus. Shares the single external memory port between the instruction-fetch requester and the mem-stage data requester. Tracks up to `OUTSTANDING` accepted transactions in an ordering FIFO and routes each in-order `data_ok`/`rdata` back to the master that issued it. Sits between the pipeline (IF and mem stages) and the bus bridge.

## Interface
- `OUTSTANDING`, 2, max accepted-but-unanswered transactions (power of two, 1..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk` in 1, single clock, rising edge
- `rst` in 1, reset; asynchronous, active-low
- `inst_req`/`inst_wr` in 1/1, fetch request / write flag
- `inst_size` in 2, 0=1B, 1=2B, 2=4B
- `inst_addr` in ADDR_W, fetch address
- `inst_wdata` in DATA_W, fetch write data (normally unused)
- `inst_rdata` out DATA_W, read data to fetch
- `inst_addr_ok`/`inst_data_ok` out 1/1, fetch address accepted / data returned
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_rdata`, `data_addr_ok`, `data_data_ok`: same set for the mem-stage master
- `m_req`/`m_wr` out 1/1, slave request / write flag
- `m_size` out 2, slave size
- `m_addr` out ADDR_W, slave address
- `m_wdata` out DATA_W, slave write data
- `m_rdata` in DATA_W, slave read data
- `m_addr_ok`/`m_data_ok` in 1/1, slave address accepted / data returned
- `busy` out 1, FIFO non-empty or `m_req` high

## Operation
- Grant: `gnt` ∈ {NONE, INST, DATA}. It selects which master's `req/wr/size/addr/wdata` drive `m_*`. With NONE, `m_*` = 0.
- Arbitration when unlocked: the data master wins if `data_req` is high, otherwise the fetch master. Round-robin applies only with the macro (see Configuration).
- Lock: if `m_req`=1 and `m_addr_ok`=0, the `gnt` register holds the current winner and the next cycle uses it regardless of the other request.
  - The lock releases on `m_addr_ok`.
  - The lock also releases if the locked master drops `req` (a protocol violation, tolerated).
- Address handshake: `m_addr_ok` passes combinationally to the granted master's `*_addr_ok`. The other master sees 0.
- Ordering FIFO: depth `OUTSTANDING`, 1-bit entries (0=INST, 1=DATA).
  - Push when `m_req && m_addr_ok`.
  - Pop when `m_data_ok`.
  - Pointers wrap modulo depth. Count is ceil(log2(OUTSTANDING))+1 bits.
- Response routing: `m_data_ok` goes combinationally to the master named at the FIFO head. `m_rdata` feeds both `*_rdata`. A `*_data_ok` is never raised for the other master.
- Full: `m_req` is forced to 0 and both `*_addr_ok` are 0. This holds even when a pop happens in the same cycle; issue resumes the next cycle.
- Empty plus `m_data_ok`: ignored. No `*_data_ok` is raised and the count stays 0.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Writes occupy FIFO entries exactly like reads. The slave returns `data_ok` for writes.

## Timing
- Reset values: `gnt`=NONE, unlocked, FIFO pointers and count 0, `busy`=0.
  - All `*_addr_ok`, `*_data_ok` and `m_req` are 0 while `rst`=0.
  - `*_rdata` follows `m_rdata`.
- Request path is zero latency: a master's `req` reaches `m_req` in the same cycle when it wins arbitration.
- The slave returns `m_data_ok` no earlier than the cycle after that request's `m_addr_ok`. The arbiter does not handle same-cycle data.
- Back-to-back: a new request may be accepted every cycle until the FIFO is full.
- Reset mid-transaction: the FIFO is cleared and responses still in flight at the slave are dropped. The bus bridge must also be reset.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration when unlocked.
  - A `last` register records the most recent master to get `m_addr_ok`.
  - When both masters request, the other master wins. `last` resets to INST, so data wins first.
- Undefined: fixed priority, data master always first. No `last` register is built.

## Test plan
- Single fetch read: `inst_req`=1 at addr 0x1FC00000, slave `addr_ok` in the same cycle, `data_ok` 2 cycles later with 0x3C080001 → `inst_addr_ok` in cycle 0, `inst_data_ok` with `inst_rdata`=0x3C080001 in cycle 2, `data_data_ok` stays 0.
- Conflict, fixed priority: both request in the same cycle (data SW 0x80000010 ← 0xDEADBEEF) → `m_addr`=0x80000010, `m_wr`=1, `m_size`=2, data accepted first, fetch accepted the next cycle. The two `data_ok`s route DATA then INST.
- Lock: data requests, slave holds `addr_ok`=0 for 3 cycles while `inst_req` stays high → `m_addr` stays on the data address for all 3 cycles and fetch is accepted only after the data `addr_ok`.
- Full: with `OUTSTANDING`=2, two requests accepted and no `data_ok` → third request sees `m_req`=0. After one `m_data_ok`, it issues the next cycle, not the same cycle.
- Spurious `m_data_ok` with an empty FIFO → no master `data_ok`, `busy`=0. Reset asserted with 2 outstanding → `busy`=0 and the FIFO empties immediately.
- With `MEM_ARB_RR_EN`: both masters request continuously and slave `addr_ok`=1 every cycle → grants alternate DATA, INST, DATA, INST.
